// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder and its round-trip
// companions (immediate-format select, reference opcodes, field bundle).
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immSrc_e;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] JAL    = 7'h6F;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
  } fields_t;

  // True when imm is a sign extension of its bits [signBit:0], i.e. every bit
  // from signBit upward agrees.
  function automatic logic immFits(input logic [31:0] imm, input int unsigned signBit);
    logic signed [31:0] hi;
    hi = $signed(imm) >>> signBit;
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-in / word-out bus of the instruction encoder; master drives fields and
// out_ready, slave (the encoder) returns the packed word, its address and error status.
interface instr_encoder_if #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 8
);
  import instr_encoder_pkg::*;

  logic              start;
  logic              in_valid;
  logic              in_ready;
  immSrc_e           ImmSrc;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output start, in_valid, ImmSrc, opcode, rd, rs1, rs2, funct3, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
  );

  modport slave (
    input  start, in_valid, ImmSrc, opcode, rd, rs1, rs2, funct3, imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
  );

endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Packs decoded fields and a signed immediate into an RV32I word for the I/S/B/J
// formats and flags immediates the format cannot hold. Purely combinational, no backpressure.
module instr_encoder_imm_pack
  import instr_encoder_pkg::*;
(
  input  immSrc_e     immSrc,
  input  logic [31:0] imm,
  input  fields_t     fields,
  output logic [31:0] word,
  output logic        err
);

  always_comb begin
    word = '0;
    err  = 1'b0;
    case (immSrc)
      IMM_I: begin
        word = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
        err  = !immFits(imm, 11);
      end
      IMM_S: begin
        word = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0], fields.opcode};
        err  = !immFits(imm, 11);
      end
      // B and J carry byte offsets whose bit 0 is implicit, so an odd offset is unencodable.
      IMM_B: begin
        word = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                imm[4:1], imm[11], fields.opcode};
        err  = !immFits(imm, 12) || imm[0];
      end
      IMM_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
        err  = !immFits(imm, 20) || imm[0];
      end
      default: begin
        word = '0;
        err  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I encoder feeding the imem loader: 2-cycle pipeline (pack stage, output stage), 1 word/cycle;
// out_ready backpressure stalls the output stage, and in_ready drops once both stages are full.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic           clk,
  input  logic           reset,
  instr_encoder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fields_t           inFields;
  logic [31:0]       packWord;
  logic              packErr;

  logic              s1Valid;
  logic [31:0]       s1Word;
  logic              s1Err;

  logic              outValid;
  logic [31:0]       outInstr;
  logic              outErr;
  logic [ADDR_W-1:0] outAddr;
  logic              zeroPend;
  logic [CNT_W-1:0]  errCnt;

  logic              s2Free;
  logic              inFire;
  logic              outFire;

  assign inFields = '{
    opcode: bus.opcode,
    rd:     bus.rd,
    rs1:    bus.rs1,
    rs2:    bus.rs2,
    funct3: bus.funct3
  };

  instr_encoder_imm_pack immPack (
    .immSrc (bus.ImmSrc),
    .imm    (bus.imm),
    .fields (inFields),
    .word   (packWord),
    .err    (packErr)
  );

  assign s2Free       = !outValid || bus.out_ready;
  assign bus.in_ready = !reset && (!s1Valid || !outValid || bus.out_ready);
  assign inFire       = bus.in_valid && bus.in_ready;
  assign outFire      = outValid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid  <= 1'b0;
      s1Word   <= '0;
      s1Err    <= 1'b0;
      outValid <= 1'b0;
      outInstr <= '0;
      outErr   <= 1'b0;
      outAddr  <= '0;
      zeroPend <= 1'b0;
      errCnt   <= '0;
    end else begin
      if (inFire) begin
        s1Valid <= 1'b1;
        s1Word  <= packWord;
        s1Err   <= packErr;
      end else if (s2Free) begin
        s1Valid <= 1'b0;
      end

      if (s2Free) begin
        outValid <= s1Valid;
        if (s1Valid) begin
          outInstr <= s1Word;
          outErr   <= s1Err;
        end
      end

      // A stalled word keeps its address through start; the restart to 0 is
      // deferred until that word leaves.
      if (bus.start) begin
        errCnt <= '0;
        if (outValid && !bus.out_ready) begin
          zeroPend <= 1'b1;
        end else begin
          outAddr  <= '0;
          zeroPend <= 1'b0;
        end
      end else if (outFire) begin
        outAddr  <= zeroPend ? '0 : outAddr + ADDR_W'(1);
        zeroPend <= 1'b0;
        if (outErr && errCnt != CNT_MAX) begin
          errCnt <= errCnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.out_valid = outValid;
  assign bus.out_instr = outInstr;
  assign bus.out_err   = outErr;
  assign bus.out_addr  = outAddr;
  assign bus.err_cnt   = errCnt;

endmodule
